shift_register_ctrl: RTL

Sequencer for the 8-bit serial-in shift register. It accepts a parallel byte over a valid/ready handshake. It then drives the register's SHIFT_ENABLE and DATA_IN pins for exactly WIDTH enabled cycles, MSB first, so that the register holds the byte when the frame ends. It sits between any byte producer and the shift register, and reports frame completion. It can optionally read the register back and check the result.

---
 rtl/shift_ctrl_pkg.sv | 18 +
 rtl/shift_ctrl_counter.sv | 32 +++
 rtl/shift_register_ctrl.sv | 121 ++++++++++++
 3 files changed

// File: rtl/shift_ctrl_pkg.sv
// Shared types and constants for the shift-register sequencer.
// The optional readback check is enabled with SHIFT_CTRL_CHECK_EN.
package shift_ctrl_pkg;

    localparam int SHIFT_CTRL_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2,
        GAP   = 2'd3
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/shift_ctrl_counter.sv
// Loadable up-counter with enable and terminal-count flag.
// Shared by the bit count (SHIFT) and the gap count (GAP).
module shift_ctrl_counter #(
    parameter int CW = 4
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_load,
    input  logic [CW-1:0] i_load_val,
    input  logic          i_en,
    input  logic [CW-1:0] i_term,
    output logic [CW-1:0] o_count,
    output logic          o_tc
);

    logic [CW-1:0] r_count;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;
    assign o_tc    = (r_count == i_term);

endmodule

// File: rtl/shift_register_ctrl.sv
// Serialises a handshaked byte MSB-first into an external serial-in shift register.
// Define SHIFT_CTRL_CHECK_EN to add the Q readback port and the MISMATCH flag.
module shift_register_ctrl
    import shift_ctrl_pkg::*;
#(
    parameter int WIDTH      = SHIFT_CTRL_WIDTH,
    parameter int GAP_CYCLES = 0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load_valid,
    input  logic [WIDTH-1:0] i_load_data,
    output logic             o_load_ready,
    input  logic             i_hold,
    output logic             o_shift_enable,
    output logic             o_data_out,
    output logic             o_busy,
`ifdef SHIFT_CTRL_CHECK_EN
    input  logic [WIDTH-1:0] i_q,
    output logic             o_mismatch,
`endif
    output logic             o_done
);

    localparam int            CW       = $clog2(max_int(WIDTH, GAP_CYCLES) + 1);
    localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] GAP_LAST = (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] w_data_shl;
    logic [CW-1:0]    w_cnt;
    logic [CW-1:0]    w_cnt_term;
    logic             w_cnt_tc;
    logic             w_cnt_en;
    logic             w_cnt_load;
    logic             w_shift_en;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_data <= '0;
        end else if (r_state == IDLE && i_load_valid) begin
            r_data <= i_load_data;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_shift_en  = 1'b0;
        w_cnt_en    = 1'b0;
        w_cnt_term  = BIT_LAST;
        case (r_state)
            IDLE: begin
                if (i_load_valid) w_state_nxt = SHIFT;
            end
            SHIFT: begin
                w_shift_en = ~i_hold;
                w_cnt_en   = ~i_hold;
                if (!i_hold && w_cnt_tc) w_state_nxt = DONE;
            end
            DONE: begin
                w_state_nxt = (GAP_CYCLES > 0) ? GAP : IDLE;
            end
            GAP: begin
                w_cnt_term = GAP_LAST;
                w_cnt_en   = 1'b1;
                if (w_cnt_tc) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Counter restarts from zero whenever a SHIFT or GAP phase is about to begin.
    assign w_cnt_load = (r_state == IDLE) || (r_state == DONE);

    shift_ctrl_counter #(
        .CW (CW)
    ) u_counter (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (w_cnt_load),
        .i_load_val ('0),
        .i_en       (w_cnt_en),
        .i_term     (w_cnt_term),
        .o_count    (w_cnt),
        .o_tc       (w_cnt_tc)
    );

    // Bit k of the frame is latched[WIDTH-1-k], i.e. the MSB after shifting left by k.
    assign w_data_shl     = r_data << w_cnt;
    assign o_shift_enable = w_shift_en;
    assign o_data_out     = w_shift_en & w_data_shl[WIDTH-1];
    assign o_load_ready   = (r_state == IDLE);
    assign o_busy         = (r_state != IDLE);
    assign o_done         = (r_state == DONE);

`ifdef SHIFT_CTRL_CHECK_EN
    logic r_mismatch;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mismatch <= 1'b0;
        end else if (r_state == DONE) begin
            r_mismatch <= (i_q != r_data);
        end
    end

    assign o_mismatch = r_mismatch;
`endif

endmodule
